dcache_ctrl: RTL

Direct-mapped, write-back, write-allocate data cache controller between the RISC-V core's word-wide load/store port and the 128-bit line-wide D-memory (SP_DRAM) port. It initiates the D_MEM_CSN/D_MEM_WEN/D_MEM_ADDR/D_MEM_DOUT line transactions; the D-memory is the responder. The core is stalled on misses. Access/miss counters are provided for performance checks in the core testbenches.

---
 rtl/dcache_ctrl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller.
// The core's word port is served from a small line array. A miss stalls the core
// while the controller optionally writes back the dirty victim line and then
// fills the requested line over the 128-bit D-memory port.
module dcache_ctrl #(
    parameter int NUM_LINES = 8,
    parameter int MEM_LAT   = 4
) (
    input  logic         CLK,
    input  logic         RSTn,
    input  logic         CPU_REQ,
    input  logic         CPU_WE,
    input  logic [13:0]  CPU_ADDR,
    input  logic [3:0]   CPU_BE,
    input  logic [31:0]  CPU_WDATA,
    output logic [31:0]  CPU_RDATA,
    output logic         CPU_STALL,
    output logic         D_MEM_CSN,
    output logic         D_MEM_WEN,
    output logic [9:0]   D_MEM_ADDR,
    output logic [127:0] D_MEM_DOUT,
    input  logic [127:0] D_MEM_DI,
    output logic [31:0]  ACC_CNT,
    output logic [31:0]  MISS_CNT
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 10 - IDX_W;
    localparam int CNT_W = $clog2(MEM_LAT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_FILL = 2'd2
    } state_t;

    // Byte-enable merge of a store into an existing word.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  be
    );
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                r[8*b +: 8] = new_w[8*b +: 8];
            end else begin
                r[8*b +: 8] = old_w[8*b +: 8];
            end
        end
        return r;
    endfunction

    // Cache storage and controller state
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [127:0]         data_q [NUM_LINES];

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 csn_q;
    logic                 wen_q;
    logic [9:0]           addr_q;
    logic [127:0]         dout_q;
    logic [31:0]          acc_q;
    logic [31:0]          miss_q;

    // Request decode
    logic [IDX_W-1:0] idx_s;
    logic [TAG_W-1:0] tag_s;
    logic [1:0]       word_s;
    logic [31:0]      rd_word_s;
    logic             hit_s;
    logic             stall_s;
    logic             miss_s;
    logic             store_hit_s;
    logic             fill_done_s;
    logic             unused_s;

    assign idx_s     = CPU_ADDR[4 +: IDX_W];
    assign tag_s     = CPU_ADDR[13 -: TAG_W];
    assign word_s    = CPU_ADDR[3:2];
    assign unused_s  = ^CPU_ADDR[1:0];
    assign rd_word_s = data_q[idx_s][{word_s, 5'b00000} +: 32];
    assign hit_s     = CPU_REQ & valid_q[idx_s] & (tag_q[idx_s] == tag_s);

    // Stall decision: only an IDLE hit or an idle core proceeds.
    always_comb begin
        stall_s = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (CPU_REQ && !hit_s) begin
                    stall_s = 1'b1;
                end else begin
                    stall_s = 1'b0;
                end
            end
            ST_WB:   stall_s = 1'b1;
            ST_FILL: stall_s = 1'b1;
            default: stall_s = 1'b1;
        endcase
    end

    assign miss_s      = (state_q == ST_IDLE) & CPU_REQ & ~hit_s;
    assign store_hit_s = RSTn & (state_q == ST_IDLE) & hit_s & CPU_WE;
    assign fill_done_s = RSTn & (state_q == ST_FILL) & (cnt_q == CNT_LAST);

    // Miss FSM: sequences write-back and fill, drives the memory port registers.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            valid_q <= '0;
            dirty_q <= '0;
            csn_q   <= 1'b1;
            wen_q   <= 1'b1;
            addr_q  <= 10'd0;
            dout_q  <= 128'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (miss_s) begin
                        if (valid_q[idx_s] && dirty_q[idx_s]) begin
                            state_q <= ST_WB;
                            csn_q   <= 1'b0;
                            wen_q   <= 1'b0;
                            addr_q  <= {tag_q[idx_s], idx_s};
                            dout_q  <= data_q[idx_s];
                        end else begin
                            state_q <= ST_FILL;
                            csn_q   <= 1'b0;
                            wen_q   <= 1'b1;
                            addr_q  <= CPU_ADDR[13:4];
                        end
                    end else if (store_hit_s) begin
                        // A hit store marks the line dirty even with no bytes enabled.
                        dirty_q[idx_s] <= 1'b1;
                    end
                end
                ST_WB: begin
                    if (cnt_q == CNT_LAST) begin
                        // Chain straight into the fill with no idle gap.
                        state_q        <= ST_FILL;
                        cnt_q          <= '0;
                        dirty_q[idx_s] <= 1'b0;
                        wen_q          <= 1'b1;
                        addr_q         <= CPU_ADDR[13:4];
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_FILL: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q        <= ST_IDLE;
                        cnt_q          <= '0;
                        valid_q[idx_s] <= 1'b1;
                        dirty_q[idx_s] <= 1'b0;
                        csn_q          <= 1'b1;
                        wen_q          <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    csn_q   <= 1'b1;
                    wen_q   <= 1'b1;
                end
            endcase
        end
    end

    // Line data and tag array: fill capture and store byte merge (never cleared).
    always_ff @(posedge CLK) begin
        if (fill_done_s) begin
            data_q[idx_s] <= D_MEM_DI;
            tag_q[idx_s]  <= tag_s;
        end else if (store_hit_s) begin
            data_q[idx_s][{word_s, 5'b00000} +: 32] <= merge_bytes(rd_word_s, CPU_WDATA, CPU_BE);
        end
    end

    // Saturating performance counters for completed accesses and misses.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            acc_q  <= 32'd0;
            miss_q <= 32'd0;
        end else begin
            if (CPU_REQ && !stall_s && (acc_q != 32'hFFFF_FFFF)) begin
                acc_q <= acc_q + 32'd1;
            end
            if (miss_s && (miss_q != 32'hFFFF_FFFF)) begin
                miss_q <= miss_q + 32'd1;
            end
        end
    end

    assign CPU_RDATA  = rd_word_s;
    assign CPU_STALL  = stall_s;
    assign D_MEM_CSN  = csn_q;
    assign D_MEM_WEN  = wen_q;
    assign D_MEM_ADDR = addr_q;
    assign D_MEM_DOUT = dout_q;
    assign ACC_CNT    = acc_q;
    assign MISS_CNT   = miss_q;

endmodule
